// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART transmit arbiter.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_END,
      GAP
   } state_e;

   localparam int unsigned ERR_CNT_W = 8;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Bits needed to hold values 0..max_val, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned D_WIDTH = 16
);
   localparam int unsigned IW = $clog2(N_REQ);

   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*D_WIDTH-1:0] req_data;
   logic [N_REQ-1:0]         req_ready;
   logic                     tx_ena;
   logic [D_WIDTH-1:0]       tx_data;
   logic                     tx_busy;
   logic [IW-1:0]            grant_id;
   logic                     grant_vld;
   logic                     frame_done;
   logic                     err_tmo;
   logic [7:0]               err_cnt;

   modport master (
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_ena, tx_data, grant_id, grant_vld, frame_done, err_tmo, err_cnt
   );

   modport slave (
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_ena, tx_data, grant_id, grant_vld, frame_done, err_tmo, err_cnt
   );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Round-robin pick: first requester above ptr, wrapping, wins.
module rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         pos = IW'((32'(ptr) + k) % N);
         if (!any && req[pos]) begin
            any        = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ word sources with round-robin grant,
// frame tracking on tx_busy, inter-frame gap and a busy watchdog.
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned D_WIDTH    = 16,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 64
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.master bus
);

   localparam int unsigned IW    = $clog2(N_REQ);
   localparam int unsigned WD_W  = cnt_width(TIMEOUT);
   localparam int unsigned GAP_W = cnt_width(GAP_CYCLES);
   localparam state_e POST_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_e                 state_q, state_nxt;
   logic [N_REQ-1:0]       arb_grant;
   logic [IW-1:0]          arb_idx;
   logic                   arb_any;
   logic [IW-1:0]          rr_ptr_q;
   logic [D_WIDTH-1:0]     sel_word;
   logic [D_WIDTH-1:0]     tx_data_q;
   logic [IW-1:0]          grant_id_q;
   logic                   tx_ena_q, grant_vld_q, frame_done_q, err_tmo_q;
   logic [ERR_CNT_W-1:0]   err_cnt_q;
   logic [WD_W-1:0]        wd_q;
   logic [GAP_W-1:0]       gap_q;
   logic                   accept_c, done_c, fire_c, wd_clr_c, wd_inc_c;
   logic                   wd_limit_c, gap_last_c;
   logic [N_REQ-1:0]       ready_c;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Word of the requester the arbiter currently favours.
   always_comb begin
      sel_word = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) sel_word = bus.req_data[i*D_WIDTH +: D_WIDTH];
      end
   end

   assign wd_limit_c = (wd_q == WD_W'(TIMEOUT - 1));
   assign gap_last_c = (gap_q == GAP_W'(GAP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      ready_c   = '0;
      accept_c  = 1'b0;
      done_c    = 1'b0;
      fire_c    = 1'b0;
      wd_clr_c  = 1'b0;
      wd_inc_c  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               ready_c   = arb_grant;
               accept_c  = 1'b1;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_clr_c  = 1'b1;
            state_nxt = WAIT_START;
         end
         WAIT_START: begin
            if (bus.tx_busy) begin
               state_nxt = WAIT_END;
            end else if (wd_limit_c) begin
               fire_c    = 1'b1;
               state_nxt = POST_FRAME;
            end else begin
               wd_inc_c = 1'b1;
            end
         end
         WAIT_END: begin
            // A completed frame wins over a watchdog expiry in the same cycle.
            if (!bus.tx_busy) begin
               done_c    = 1'b1;
               state_nxt = POST_FRAME;
            end else if (wd_limit_c) begin
               fire_c    = 1'b1;
               state_nxt = POST_FRAME;
            end else begin
               wd_inc_c = 1'b1;
            end
         end
         GAP: begin
            if (gap_last_c) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_ena_q     <= 1'b0;
         tx_data_q    <= '0;
         grant_id_q   <= '0;
         grant_vld_q  <= 1'b0;
         frame_done_q <= 1'b0;
         err_tmo_q    <= 1'b0;
         err_cnt_q    <= '0;
         rr_ptr_q     <= IW'(N_REQ - 1);
         wd_q         <= '0;
         gap_q        <= '0;
      end else begin
         tx_ena_q     <= accept_c;
         frame_done_q <= done_c;
         err_tmo_q    <= fire_c;
         grant_vld_q  <= (state_nxt == LAUNCH) || (state_nxt == WAIT_START) ||
                         (state_nxt == WAIT_END);
         if (accept_c) begin
            tx_data_q  <= sel_word;
            grant_id_q <= arb_idx;
            rr_ptr_q   <= arb_idx;
         end
         if (fire_c && (err_cnt_q != ERR_CNT_MAX)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
         if (wd_clr_c)      wd_q <= '0;
         else if (wd_inc_c) wd_q <= wd_q + WD_W'(1);
         gap_q <= (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
      end
   end

   assign bus.req_ready  = ready_c;
   assign bus.tx_ena     = tx_ena_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.grant_id   = grant_id_q;
   assign bus.grant_vld  = grant_vld_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err_tmo    = err_tmo_q;
   assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a cycle-timing reference model
// plus a behavioural transmitter.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int GAPC  = 2;
   localparam int TMO   = 64;
   localparam int DEPTH = 512;
   localparam int NEVER = 1 << 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N), .D_WIDTH(DW)) bus ();

   uart_tx_arbiter #(
      .N_REQ(N), .D_WIDTH(DW), .GAP_CYCLES(GAPC), .TIMEOUT(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rst_req;

   // per-requester word FIFOs
   logic [DW-1:0] fifo [N][DEPTH];
   int            head [N];
   int            cnt  [N];
   logic [N-1:0]  hold;

   // reference model
   int            m_ptr, idle_at, launch_at, gv_end, done_at, tmo_at, m_err, m_gid;
   logic [DW-1:0] m_data;

   // transmitter model and frame shaping
   int busy_from, busy_to, pend_s, pend_b;
   bit pend_never, f_rand, f_never;
   int f_s, f_b;

   // observations
   int            glog[$];
   int            ena_cnt, done_cnt, tmo_cnt, last_ena_cyc, last_tmo_cyc;
   logic [DW-1:0] last_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 1; k <= N; k++) begin
         int j;
         j = (p + k) % N;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic push(input int i, input logic [DW-1:0] w);
      fifo[i][(head[i] + cnt[i]) % DEPTH] = w;
      cnt[i]++;
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (cnt[i] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_ptr     = N - 1;
      idle_at   = cyc + 1;
      launch_at = -1;
      gv_end    = -2;
      done_at   = -1;
      tmo_at    = -1;
      m_err     = 0;
      m_gid     = 0;
      m_data    = '0;
      busy_from = NEVER;
      busy_to   = -1;
   endtask

   // One clock: drive inputs, compare outputs, then advance the model.
   task automatic step();
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      logic [N-1:0]    er;
      int              w, fe, lc;
      @(negedge clk);
      cyc++;
      rst = rst_req;
      for (int i = 0; i < N; i++) begin
         v[i] = (cnt[i] != 0) && !hold[i];
         d[i*DW +: DW] = (cnt[i] != 0) ? fifo[i][head[i]] : DW'($urandom);
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.tx_busy   = (cyc >= busy_from) && (cyc <= busy_to);
      #1;
      if (cyc == tmo_at) m_err = (m_err < 255) ? m_err + 1 : 255;
      w  = (cyc >= idle_at) ? pick(v, m_ptr) : -1;
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      check_eq("req_ready",  32'(bus.req_ready),  32'(er));
      check_eq("tx_ena",     32'(bus.tx_ena),     32'(cyc == launch_at));
      check_eq("grant_vld",  32'(bus.grant_vld),  32'(cyc >= launch_at && cyc <= gv_end));
      check_eq("frame_done", 32'(bus.frame_done), 32'(cyc == done_at));
      check_eq("err_tmo",    32'(bus.err_tmo),    32'(cyc == tmo_at));
      check_eq("tx_data",    32'(bus.tx_data),    32'(m_data));
      check_eq("grant_id",   32'(bus.grant_id),   32'(m_gid));
      check_eq("err_cnt",    32'(bus.err_cnt),    32'(m_err));
      if (bus.tx_ena) begin
         ena_cnt++;
         glog.push_back(int'(bus.grant_id));
         last_ena_cyc = cyc;
         last_data    = bus.tx_data;
         busy_from    = pend_never ? NEVER : cyc + 1 + pend_s;
         busy_to      = cyc + pend_s + pend_b;
      end
      if (bus.frame_done) done_cnt++;
      if (bus.err_tmo) begin
         tmo_cnt++;
         last_tmo_cyc = cyc;
      end
      if (rst_req) begin
         model_reset();
      end else if (w >= 0) begin
         m_data    = fifo[w][head[w]];
         head[w]   = (head[w] + 1) % DEPTH;
         cnt[w]--;
         m_gid     = w;
         m_ptr     = w;
         lc        = cyc + 1;
         launch_at = lc;
         pend_never = f_never;
         pend_s     = f_rand ? int'($urandom_range(0, 4)) : f_s;
         pend_b     = f_rand ? int'($urandom_range(1, 25)) : f_b;
         if (pend_never) begin
            tmo_at  = lc + TMO + 1;
            gv_end  = lc + TMO;
            done_at = -1;
            idle_at = lc + TMO + GAPC + 1;
         end else begin
            fe      = lc + 1 + pend_s + pend_b;
            done_at = fe + 1;
            gv_end  = fe;
            tmo_at  = -1;
            idle_at = fe + GAPC + 1;
         end
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((cyc < idle_at || pending()) && n < budget) begin
         step();
         n++;
      end
      check_eq("idle_budget", 32'(n >= budget), 32'(0));
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
   endtask

   initial begin
      int n0, pushed, d0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy   = 1'b0;
      hold = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         cnt[i]  = 0;
      end
      f_rand = 1'b0; f_never = 1'b0; f_s = 1; f_b = 20;
      pend_s = 0; pend_b = 1; pend_never = 1'b0;
      ena_cnt = 0; done_cnt = 0; tmo_cnt = 0; last_ena_cyc = 0; last_tmo_cyc = 0;
      last_data = '0;
      model_reset();

      // reset
      rst_req = 1'b1;
      repeat (3) step();
      rst_req = 1'b0;

      // single requester, 20-cycle frame
      push(0, 16'hA5C3);
      run_until_idle(200);
      check_eq("single_ena",  32'(ena_cnt), 32'(1));
      check_eq("single_done", 32'(done_cnt), 32'(1));
      check_eq("single_data", 32'(last_data), 32'(16'hA5C3));
      check_eq("single_gid",  32'(glog[0]), 32'(0));

      // all four requesting continuously
      do_reset();
      glog.delete();
      f_rand = 1'b1;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, DW'($urandom));
      run_until_idle(1000);
      check_eq("all4_frames", 32'(glog.size()), 32'(8));
      for (int k = 0; k < 5; k++) check_eq("all4_order", 32'(glog[k]), 32'(k % N));

      // req2 alone, then req1 and req3 together
      glog.delete();
      push(2, DW'($urandom));
      n0 = 0;
      while (cyc != launch_at && n0 < 20) begin
         step();
         n0++;
      end
      push(1, DW'($urandom));
      push(3, DW'($urandom));
      run_until_idle(500);
      check_eq("wrap_frames", 32'(glog.size()), 32'(3));
      check_eq("wrap_g0", 32'(glog[0]), 32'(2));
      check_eq("wrap_g1", 32'(glog[1]), 32'(3));
      check_eq("wrap_g2", 32'(glog[2]), 32'(1));

      // random traffic with requesters withdrawing valid
      n0 = ena_cnt;
      pushed = 0;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            push(int'($urandom_range(0, N - 1)), DW'($urandom));
            pushed++;
         end
         if ($urandom_range(0, 7) == 0) hold[$urandom_range(0, N - 1)] ^= 1'b1;
         step();
      end
      hold = '0;
      run_until_idle(20000);
      check_eq("rand_frames", 32'(ena_cnt - n0), 32'(pushed));

      // reset while the frame is in WAIT_END
      f_rand = 1'b0; f_s = 0; f_b = 30;
      n0 = ena_cnt;
      push(1, DW'($urandom));
      d0 = 0;
      while (!(ena_cnt > n0 && cyc >= last_ena_cyc + 4) && d0 < 60) begin
         step();
         d0++;
      end
      do_reset();
      push(0, DW'($urandom));
      push(1, DW'($urandom));
      push(2, DW'($urandom));
      glog.delete();
      step();
      check_eq("rst_ready",  32'(bus.req_ready), 32'(1));
      check_eq("rst_gvld",   32'(bus.grant_vld), 32'(0));
      check_eq("rst_txdata", 32'(bus.tx_data), 32'(0));
      run_until_idle(500);
      check_eq("rst_first", 32'(glog[0]), 32'(0));

      // watchdog: transmitter never goes busy
      f_never = 1'b1;
      tmo_cnt = 0;
      d0 = done_cnt;
      push(0, DW'($urandom));
      run_until_idle(200);
      check_eq("tmo_lat",    32'(last_tmo_cyc - last_ena_cyc), 32'(TMO + 1));
      check_eq("tmo_once",   32'(tmo_cnt), 32'(1));
      check_eq("tmo_errcnt", 32'(bus.err_cnt), 32'(1));
      check_eq("tmo_nodone", 32'(done_cnt - d0), 32'(0));
      for (int i = 0; i < 299; i++) push(0, DW'($urandom));
      run_until_idle(300 * 80);
      check_eq("tmo_total", 32'(tmo_cnt), 32'(300));
      check_eq("err_sat",   32'(bus.err_cnt), 32'(255));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
